diferential_cfg_loader: RTL and testbench

Configuration sequencer for the mux-cell array. It accepts a framed stream of 4-bit configuration nibbles from the chip pins (one per cell, followed by an XOR checksum nibble) and drives a serial shift chain that feeds every cell. It pulses a commit strobe, then enables array operation. It holds the array stopped (run_en low) during loading and after a checksum error.

---
 rtl/diferential_pkg.sv | 18 +
 rtl/diferential_cfg_chain.sv | 31 +++
 rtl/diferential_cfg_loader.sv | 109 ++++++++++
 tb/tb_diferential_cfg_loader.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/diferential_pkg.sv
// Shared defaults and FSM encoding for the mux-cell array configuration loader.
package diferential_pkg;

   localparam int ROWS_DEF   = 6;
   localparam int COLS_DEF   = 6;
   localparam int BITS_DEF   = 4;
   localparam int NCELLS_DEF = ROWS_DEF * COLS_DEF;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      CHECK  = 3'd2,
      COMMIT = 3'd3,
      RUN    = 3'd4,
      ERROR  = 3'd5
   } state_t;

endpackage

// File: rtl/diferential_cfg_chain.sv
// Per-cell configuration shift chain with a shadow register made live on cfg_commit.
// The first nibble shifted in a frame ends up in cell 0.
module diferential_cfg_chain
   import diferential_pkg::*;
#(
   parameter int ROWS = ROWS_DEF,
   parameter int COLS = COLS_DEF,
   parameter int BITS = BITS_DEF
) (
   input  logic                       clk,
   input  logic                       cfg_shift,
   input  logic [BITS-1:0]            cfg_data,
   input  logic                       cfg_commit,
   output logic [ROWS*COLS*BITS-1:0]  live_cfg
);

   localparam int W = ROWS * COLS * BITS;

   logic [W-1:0] chain;

   // No reset: an aborted load must leave the live configuration untouched.
   always_ff @(posedge clk) begin
      if (cfg_shift) begin
         chain <= {cfg_data, chain[W-1:BITS]};
      end
      if (cfg_commit) begin
         live_cfg <= chain;
      end
   end

endmodule

// File: rtl/diferential_cfg_loader.sv
// Framed nibble loader: streams per-cell config into the shift chain, verifies the
// trailing XOR checksum, then pulses commit and enables the array.
module diferential_cfg_loader
   import diferential_pkg::*;
#(
   parameter int ROWS = ROWS_DEF,
   parameter int COLS = COLS_DEF,
   parameter int BITS = BITS_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [BITS-1:0] nib_in,
   input  logic            nib_valid,
   output logic            nib_ready,
   output logic            cfg_shift,
   output logic [BITS-1:0] cfg_data,
   output logic            cfg_commit,
   output logic            run_en,
   output logic            busy,
   output logic            done,
   output logic            err
);

   localparam int NCELLS = ROWS * COLS;
   localparam int CW     = $clog2(NCELLS + 1);

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [BITS-1:0] csum, csum_nx;
   logic            accept;

   logic            nib_ready_nx, cfg_shift_nx, cfg_commit_nx;
   logic            run_en_nx, busy_nx, done_nx, err_nx;
   logic [BITS-1:0] cfg_data_nx;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      csum_nx  = csum;
      accept   = nib_valid && nib_ready && !start;

      // start re-syncs from every state except COMMIT, which always completes.
      if (start && (state != COMMIT)) begin
         state_nx = LOAD;
         cnt_nx   = '0;
         csum_nx  = '0;
      end else begin
         case (state)
            IDLE, RUN, ERROR: ;
            LOAD: begin
               if (accept) begin
                  cnt_nx  = cnt + CW'(1);
                  csum_nx = csum ^ nib_in;
                  if (cnt_nx == CW'(NCELLS)) begin
                     state_nx = CHECK;
                  end
               end
            end
            CHECK: begin
               if (accept) begin
                  state_nx = (nib_in == csum) ? COMMIT : ERROR;
               end
            end
            COMMIT:  state_nx = RUN;
            default: state_nx = IDLE;
         endcase
      end

      nib_ready_nx  = (state_nx == LOAD) || (state_nx == CHECK);
      cfg_shift_nx  = (state == LOAD) && accept;
      cfg_data_nx   = cfg_shift_nx ? nib_in : cfg_data;
      cfg_commit_nx = (state == COMMIT);
      // run_en trails RUN entry by one cycle so it follows the commit pulse.
      run_en_nx     = (state == RUN) && (state_nx == RUN);
      busy_nx       = (state_nx == LOAD) || (state_nx == CHECK) || (state_nx == COMMIT);
      done_nx       = (state_nx == RUN);
      err_nx        = (state_nx == ERROR);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         csum       <= '0;
         nib_ready  <= 1'b0;
         cfg_shift  <= 1'b0;
         cfg_data   <= '0;
         cfg_commit <= 1'b0;
         run_en     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         csum       <= csum_nx;
         nib_ready  <= nib_ready_nx;
         cfg_shift  <= cfg_shift_nx;
         cfg_data   <= cfg_data_nx;
         cfg_commit <= cfg_commit_nx;
         run_en     <= run_en_nx;
         busy       <= busy_nx;
         done       <= done_nx;
         err        <= err_nx;
      end
   end

endmodule

// File: tb/tb_diferential_cfg_loader.sv
// Directed bench for the config loader driving the config chain as its consumer.
module tb_diferential_cfg_loader;
   import diferential_pkg::*;

   localparam int NC = NCELLS_DEF;
   localparam int B  = BITS_DEF;

   logic          clk = 1'b0;
   logic          reset, start, nib_valid;
   logic [B-1:0]  nib_in;
   logic          nib_ready, cfg_shift, cfg_commit, run_en, busy, done, err;
   logic [B-1:0]  cfg_data;
   logic [NC*B-1:0] live_cfg;

   always #5 clk = ~clk;

   diferential_cfg_loader #(.ROWS(ROWS_DEF), .COLS(COLS_DEF), .BITS(BITS_DEF)) dut (
      .clk(clk), .reset(reset), .start(start), .nib_in(nib_in), .nib_valid(nib_valid),
      .nib_ready(nib_ready), .cfg_shift(cfg_shift), .cfg_data(cfg_data),
      .cfg_commit(cfg_commit), .run_en(run_en), .busy(busy), .done(done), .err(err)
   );

   diferential_cfg_chain #(.ROWS(ROWS_DEF), .COLS(COLS_DEF), .BITS(BITS_DEF)) chain (
      .clk(clk), .cfg_shift(cfg_shift), .cfg_data(cfg_data),
      .cfg_commit(cfg_commit), .live_cfg(live_cfg)
   );

   int total = 0;
   int bad   = 0;
   int shifts = 0;
   int commits = 0;
   logic [B-1:0] shq[$];

   always @(negedge clk) begin
      if (cfg_shift === 1'b1) begin
         shifts++;
         shq.push_back(cfg_data);
      end
      if (cfg_commit === 1'b1) commits++;
   end

   // {nib_ready, cfg_shift, cfg_commit, run_en, busy, done, err}
   function automatic logic [6:0] outs();
      return {nib_ready, cfg_shift, cfg_commit, run_en, busy, done, err};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic v, input logic [B-1:0] n);
      start     = s;
      nib_valid = v;
      nib_in    = n;
      @(posedge clk);
      #1;
      start     = 1'b0;
      nib_valid = 1'b0;
   endtask

   task automatic send_frame(input int mode, input logic [B-1:0] ck);
      for (int i = 0; i < NC; i++) begin
         drive(1'b0, 1'b1, B'(i));
         if (mode == 1) drive(1'b0, 1'b0, 4'hF);
      end
      drive(1'b0, 1'b1, ck);
   endtask

   task automatic tail();
      repeat (4) drive(1'b0, 1'b0, '0);
   endtask

   // Last NC shifted nibbles must be 0,1,..,F,0,.. and the live cells must hold the same.
   task automatic chk_payload(input string name);
      int nmis;
      nmis = 0;
      chk({name, "_qlen_ok"}, 32'(shq.size() >= NC), 32'd1);
      if (shq.size() >= NC) begin
         for (int k = 0; k < NC; k++)
            if (shq[shq.size() - NC + k] !== B'(k)) nmis++;
      end
      chk({name, "_data_mis"}, 32'(nmis), 32'd0);
      nmis = 0;
      for (int k = 0; k < NC; k++)
         if (live_cfg[k*B +: B] !== B'(k)) nmis++;
      chk({name, "_live_mis"}, 32'(nmis), 32'd0);
   endtask

   typedef struct {
      int         mode;      // 0 back-to-back, 1 valid toggling, 2 restart after 20
      logic [3:0] ck;
      int         exp_shifts;
      int         exp_commits;
      logic [6:0] exp_outs;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int s0, c0;

      tbl[0] = '{0, 4'h0, 36, 1, 7'b0001010};
      tbl[1] = '{0, 4'h5, 36, 0, 7'b0000001};
      tbl[2] = '{0, 4'h0, 36, 1, 7'b0001010};
      tbl[3] = '{1, 4'h0, 36, 1, 7'b0001010};
      tbl[4] = '{2, 4'h0, 56, 1, 7'b0001010};
      tbl[5] = '{1, 4'h9, 36, 0, 7'b0000001};

      reset = 1'b1; start = 1'b0; nib_valid = 1'b0; nib_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", 32'(outs()), 32'd0);
      reset = 1'b0;

      s0 = shifts;
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b1, B'(i + 3));
         chk($sformatf("idle_outs%0d", i), 32'(outs()), 32'd0);
      end
      chk("idle_no_shift", 32'(shifts - s0), 32'd0);

      // First frame by hand: entry, shift latency, commit latency, start ignored in COMMIT.
      s0 = shifts; c0 = commits;
      drive(1'b1, 1'b0, '0);
      chk("load_entry", 32'(outs()), 32'b1000100);
      drive(1'b0, 1'b1, 4'h0);
      chk("first_shift", 32'(outs()), 32'b1100100);
      chk("first_data", 32'(cfg_data), 32'h0);
      for (int i = 1; i < NC; i++) drive(1'b0, 1'b1, B'(i));
      chk("last_data", 32'(cfg_data), 32'h3);
      drive(1'b0, 1'b1, 4'h0);
      chk("in_commit", 32'(outs()), 32'b0000100);
      drive(1'b1, 1'b0, '0);
      chk("commit_pulse", 32'(outs()), 32'b0010010);
      drive(1'b0, 1'b0, '0);
      chk("run_after", 32'(outs()), 32'b0001010);
      chk("hand_shifts", 32'(shifts - s0), 32'd36);
      chk("hand_commits", 32'(commits - c0), 32'd1);
      chk_payload("hand");

      for (int t = 0; t < 6; t++) begin
         s0 = shifts; c0 = commits;
         drive(1'b1, 1'b0, '0);
         if (tbl[t].mode == 2) begin
            for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, B'(i));
            drive(1'b1, 1'b1, 4'hA);
         end
         send_frame(tbl[t].mode, tbl[t].ck);
         tail();
         chk($sformatf("v%0d_shifts", t), 32'(shifts - s0), 32'(tbl[t].exp_shifts));
         chk($sformatf("v%0d_commits", t), 32'(commits - c0), 32'(tbl[t].exp_commits));
         chk($sformatf("v%0d_outs", t), 32'(outs()), 32'(tbl[t].exp_outs));
         chk_payload($sformatf("v%0d", t));
      end

      // Reset on nibble 30 aborts the frame without a commit.
      s0 = shifts; c0 = commits;
      drive(1'b1, 1'b0, '0);
      for (int i = 0; i < 30; i++) drive(1'b0, 1'b1, B'(i));
      reset = 1'b1;
      drive(1'b0, 1'b1, B'(30));
      chk("midreset_outs", 32'(outs()), 32'd0);
      reset = 1'b0;
      drive(1'b0, 1'b1, B'(31));
      chk("midreset_idle", 32'(outs()), 32'd0);
      chk("midreset_shifts", 32'(shifts - s0), 32'd30);
      chk("midreset_commits", 32'(commits - c0), 32'd0);
      s0 = shifts; c0 = commits;
      drive(1'b1, 1'b0, '0);
      send_frame(0, 4'h0);
      tail();
      chk("after_reset_outs", 32'(outs()), 32'b0001010);
      chk("after_reset_shifts", 32'(shifts - s0), 32'd36);
      chk("after_reset_commits", 32'(commits - c0), 32'd1);
      chk_payload("after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
